// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 16-bit ALU between two requesters.
// Accepts one operation at a time and returns the registered result over valid/ready.
module alu_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    output logic [WIDTH-1:0] r0_rsp_result,
    output logic             r0_rsp_err,
    input  logic             r0_rsp_ready,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    output logic [WIDTH-1:0] r1_rsp_result,
    output logic             r1_rsp_err,
    input  logic             r1_rsp_ready,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [OPW-1:0] OpReserved = {OPW{1'b1}};

    state_e           state_q;
    logic             last_grant_q;
    logic             grant_id_q;
    logic [OPW-1:0]   alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;

    logic winner;
    logic accept;
    logic rsp_ready_sel;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = r1_valid;
        if (r0_valid && r1_valid) begin
            winner = ~last_grant_q;
        end
    end

    assign r0_ready      = (state_q == StIdle) && r0_valid && !winner;
    assign r1_ready      = (state_q == StIdle) && r1_valid && winner;
    assign accept        = r0_ready || r1_ready;
    assign rsp_ready_sel = grant_id_q ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        grant_id_q <= winner;
                        alu_op_q   <= winner ? r1_op : r0_op;
                        alu_a_q    <= winner ? r1_a : r0_a;
                        alu_b_q    <= winner ? r1_b : r0_b;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    result_q <= (alu_op_q == OpReserved) ? '0 : alu_result;
                    err_q    <= (alu_op_q == OpReserved);
                    state_q  <= StResp;
                end
                StResp: begin
                    if (rsp_ready_sel) begin
                        last_grant_q <= grant_id_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign busy          = (state_q != StIdle);
    assign grant_id      = grant_id_q;
    assign r0_rsp_valid  = (state_q == StResp) && !grant_id_q;
    assign r1_rsp_valid  = (state_q == StResp) && grant_id_q;
    assign r0_rsp_result = result_q;
    assign r1_rsp_result = result_q;
    assign r0_rsp_err    = err_q;
    assign r1_rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU alongside.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [2:0]  r0_op, r1_op, alu_op;
    logic [15:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_result;
    logic        r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
    logic [15:0] r0_rsp_result, r1_rsp_result;
    logic        r0_rsp_ready, r1_rsp_ready;
    logic        busy, grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Reserved opcode returns a non-zero value so the block's forcing to 0 is visible.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = alu_a << alu_b[3:0];
            3'b110:  alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 16'h1234;
        endcase
    end

    alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_result(r0_rsp_result), .r0_rsp_err(r0_rsp_err),
        .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_result(r1_rsp_result), .r1_rsp_err(r1_rsp_err),
        .r1_rsp_ready(r1_rsp_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        r0_valid = 0; r1_valid = 0; r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_op = 0; r1_op = 0; r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
        rst = 1'b1;
        #12;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %b want 0", grant_id); end
        n_checks++; if ({alu_op, alu_a, alu_b} !== 35'd0) begin n_fail++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_op, alu_a, alu_b); end
        n_checks++; if ({r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready} !== 4'b0) begin n_fail++; $display("FAIL reset_hs got %b want 0000", {r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready}); end
        n_checks++; if ({r0_rsp_result, r0_rsp_err} !== 17'd0) begin n_fail++; $display("FAIL reset_rsp got %h/%b want 0/0", r0_rsp_result, r0_rsp_err); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        r0_valid = 1; r0_op = 3'b000; r0_a = 16'h5555; r0_b = 16'h3333;
        #1;
        n_checks++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got %b want 1", r0_ready); end
        @(negedge clk);
        r0_valid = 0;
        #1;
        n_checks++; if (r0_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL add_exec ready/busy got %b/%b want 0/1", r0_ready, busy); end
        n_checks++; if (alu_a !== 16'h5555 || alu_b !== 16'h3333 || alu_op !== 3'b000) begin n_fail++; $display("FAIL add_alu got %h/%h/%h want 0/5555/3333", alu_op, alu_a, alu_b); end
        n_checks++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_rsp got %b want 0", r0_rsp_valid); end
        @(negedge clk);
        n_checks++; if (r0_rsp_valid !== 1'b1 || r0_rsp_result !== 16'h8888 || r0_rsp_err !== 1'b0) begin n_fail++; $display("FAIL add_rsp got %b/%h/%b want 1/8888/0", r0_rsp_valid, r0_rsp_result, r0_rsp_err); end
        n_checks++; if (r1_rsp_valid !== 1'b0 || grant_id !== 1'b0) begin n_fail++; $display("FAIL add_other got %b/%b want 0/0", r1_rsp_valid, grant_id); end
        r0_rsp_ready = 1;
        @(negedge clk);
        r0_rsp_ready = 0;
        #1;
        n_checks++; if (busy !== 1'b0 || r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_done busy/valid got %b/%b want 0/0", busy, r0_rsp_valid); end
        n_checks++; if (alu_a !== 16'h5555) begin n_fail++; $display("FAIL add_hold_alu got %h want 5555", alu_a); end
    endtask

    task automatic test_contention();
        do_reset();
        r0_valid = 1; r0_op = 3'b010; r0_a = 16'h9999; r0_b = 16'h3333;
        r1_valid = 1; r1_op = 3'b100; r1_a = 16'h5555; r1_b = 16'hAAAA;
        #1;
        n_checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin n_fail++; $display("FAIL tie_first got %b%b want 10", r0_ready, r1_ready); end
        @(negedge clk);
        r0_valid = 0;
        @(negedge clk);
        n_checks++; if (r0_rsp_valid !== 1'b1 || r0_rsp_result !== 16'h6666) begin n_fail++; $display("FAIL tie_r0_rsp got %b/%h want 1/6666", r0_rsp_valid, r0_rsp_result); end
        n_checks++; if (r1_ready !== 1'b0) begin n_fail++; $display("FAIL tie_r1_wait got %b want 0", r1_ready); end
        r0_rsp_ready = 1;
        @(negedge clk);
        r0_rsp_ready = 0;
        #1;
        n_checks++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL tie_r1_next got %b want 1", r1_ready); end
        @(negedge clk);
        r1_valid = 0;
        @(negedge clk);
        n_checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_result !== 16'hFFFF || grant_id !== 1'b1) begin n_fail++; $display("FAIL tie_r1_rsp got %b/%h/%b want 1/ffff/1", r1_rsp_valid, r1_rsp_result, grant_id); end
        r1_rsp_ready = 1;
        @(negedge clk);
        r1_rsp_ready = 0;
    endtask

    task automatic test_alternate();
        logic        exp;
        logic [15:0] exp_res;
        r0_valid = 1; r1_valid = 1; r0_rsp_ready = 1; r1_rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp = i[0];
            exp_res = exp ? 16'hFFFF : 16'h6666;
            #1;
            n_checks++; if (r0_ready !== !exp || r1_ready !== exp) begin n_fail++; $display("FAIL alt_ready%0d got %b%b want %b%b", i, r0_ready, r1_ready, !exp, exp); end
            repeat (2) @(negedge clk);
            n_checks++; if (grant_id !== exp || (exp ? r1_rsp_result : r0_rsp_result) !== exp_res) begin n_fail++; $display("FAIL alt_rsp%0d got %b/%h want %b/%h", i, grant_id, exp ? r1_rsp_result : r0_rsp_result, exp, exp_res); end
            @(negedge clk);
        end
        r0_valid = 0; r1_valid = 0; r0_rsp_ready = 0; r1_rsp_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        r1_valid = 1; r1_op = 3'b001; r1_a = 16'hF0F0; r1_b = 16'h3C3C;
        @(negedge clk);
        r1_valid = 0;
        @(negedge clk);
        r0_valid = 1; r0_op = 3'b000; r0_a = 16'h0001; r0_b = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_result !== 16'h3030 || r0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d got %b/%h/%b want 1/3030/0", i, r1_rsp_valid, r1_rsp_result, r0_ready); end
            @(negedge clk);
        end
        r1_rsp_ready = 1;
        @(negedge clk);
        r1_rsp_ready = 0;
        #1;
        n_checks++; if (r0_ready !== 1'b1 || r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b/%b want 1/0", r0_ready, r1_rsp_valid); end
        @(negedge clk);
        r0_valid = 0;
        @(negedge clk);
        n_checks++; if (r0_rsp_valid !== 1'b1 || r0_rsp_result !== 16'h0002) begin n_fail++; $display("FAIL bp_r0_rsp got %b/%h want 1/0002", r0_rsp_valid, r0_rsp_result); end
        r0_rsp_ready = 1;
        @(negedge clk);
        r0_rsp_ready = 0;
    endtask

    task automatic test_reserved();
        r0_valid = 1; r0_op = 3'b111; r0_a = 16'h1111; r0_b = 16'h2222;
        @(negedge clk);
        r0_valid = 0;
        #1;
        n_checks++; if (alu_result !== 16'h1234) begin n_fail++; $display("FAIL rsv_alu got %h want 1234", alu_result); end
        @(negedge clk);
        n_checks++; if (r0_rsp_valid !== 1'b1 || r0_rsp_result !== 16'h0000 || r0_rsp_err !== 1'b1) begin n_fail++; $display("FAIL rsv_rsp got %b/%h/%b want 1/0000/1", r0_rsp_valid, r0_rsp_result, r0_rsp_err); end
        r0_rsp_ready = 1;
        @(negedge clk);
        r0_rsp_ready = 0;
    endtask

    task automatic test_reset_mid_op();
        r0_valid = 1; r0_op = 3'b000; r0_a = 16'h0100; r0_b = 16'h0200;
        @(negedge clk);
        r0_valid = 0;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_now got %b/%b/%b want 0/0/0", busy, r0_rsp_valid, r1_rsp_valid); end
        n_checks++; if (alu_a !== 16'h0000 || r0_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rmid_regs got %h/%b want 0000/0", alu_a, r0_rsp_err); end
        @(negedge clk);
        rst = 1'b0;
        r1_valid = 1; r1_op = 3'b011; r1_a = 16'h00F0; r1_b = 16'h0F00;
        #1;
        n_checks++; if (r1_ready !== 1'b1 || r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_accept got %b/%b want 1/0", r1_ready, r0_rsp_valid); end
        @(negedge clk);
        r1_valid = 0;
        @(negedge clk);
        n_checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_result !== 16'h0FF0 || r1_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp got %b/%h/%b want 1/0ff0/0", r1_rsp_valid, r1_rsp_result, r1_rsp_err); end
        r1_rsp_ready = 1;
        @(negedge clk);
        r1_rsp_ready = 0;
    endtask

    task automatic test_stray_handshake();
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_idle got %b/%b/%b want 0/0/0", busy, r0_rsp_valid, r1_rsp_valid); end
        r0_rsp_ready = 0;
        r0_valid = 1; r0_op = 3'b101; r0_a = 16'h0003; r0_b = 16'h0004;
        @(negedge clk);
        r0_valid = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (r0_rsp_valid !== 1'b1 || r0_rsp_result !== 16'h0030 || busy !== 1'b1) begin n_fail++; $display("FAIL stray_other%0d got %b/%h/%b want 1/0030/1", i, r0_rsp_valid, r0_rsp_result, busy); end
            @(negedge clk);
        end
        r1_rsp_ready = 0; r0_rsp_ready = 1;
        @(negedge clk);
        r0_rsp_ready = 0;
        n_checks++; if (busy !== 1'b0 || r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_done got %b/%b want 0/0", busy, r0_rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_alternate();
        test_backpressure();
        test_reserved();
        test_reset_mid_op();
        test_stray_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit combinational ALU between two requesters (e.g. an issue port and an address-generation port). It arbitrates round-robin and registers the granted operation onto the ALU inputs. It then captures the ALU result and returns it to the winner over a valid/ready response handshake. One operation is in flight at a time; the ALU itself stays outside this block.

## Interface
- WIDTH, 16, operand/result width
- OPW, 3, ALU opcode width (000 add, 001 and, 010 sub, 011 or, 100 xor, 101 sll, 110 slt, 111 reserved)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- r0_valid / r1_valid  in  1  request pending
- r0_ready / r1_ready  out  1  request accepted this cycle
- r0_op / r1_op  in  OPW  opcode
- r0_a, r0_b / r1_a, r1_b  in  WIDTH  operands
- r0_rsp_valid / r1_rsp_valid  out  1  result available
- r0_rsp_result / r1_rsp_result  out  WIDTH  result
- r0_rsp_err / r1_rsp_err  out  1  reserved opcode was issued
- r0_rsp_ready / r1_rsp_ready  in  1  requester takes result
- alu_op  out  OPW  to ALU operation
- alu_a, alu_b  out  WIDTH  to ALU operands
- alu_result  in  WIDTH  from ALU result
- busy  out  1  state != IDLE
- grant_id  out  1  requester owning current/last transaction

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - winner = the only valid requester.
  - If both are valid, winner = requester != last_grant.
  - After reset, last_grant = 1, so r0 wins the first tie.
- rN_ready is combinational, high only in IDLE for the winner.
- Transfer occurs when rN_valid && rN_ready.
- On transfer:
  - Latch op/a/b into alu_op/alu_a/alu_b registers.
  - grant_id <= winner; go to EXEC.
- EXEC: alu_* held stable.
  - At the edge, result_q <= alu_result, or 0 when op == 111; err_q <= (op == 111).
  - Go to RESP.
- RESP:
  - r{grant_id}_rsp_valid = 1; rsp_result = result_q; rsp_err = err_q.
  - Other requester's rsp_valid = 0.
  - Stay until r{grant_id}_rsp_ready; then last_grant <= grant_id and go to IDLE.
- rsp_result/rsp_err are driven from result_q/err_q to both ports; only valid qualifies them.
- Requests arriving in EXEC/RESP see ready = 0 and must hold until accepted.
- A requester may drop valid before acceptance; there is no obligation either way.
- alu_op/alu_a/alu_b keep the last issued values in IDLE; they do not return to zero.
- Arithmetic is the ALU's; this block only forces the result to 0 for reserved opcode 111.

## Timing
- Reset values:
  - State IDLE; last_grant = 1; grant_id = 0.
  - alu_op = 0, alu_a = 0, alu_b = 0; result_q = 0; err_q = 0.
  - busy = 0; all rsp_valid = 0.
  - rN_ready = 0 unless rN_valid (combinational, IDLE).
- Latency: acceptance at edge T.
  - alu_* valid after T.
  - Result captured at T+1.
  - rsp_valid high from T+1.
- Minimum 3 cycles per operation when rsp_ready is tied high: accept, EXEC, RESP with handshake, then IDLE to accept the next.
- Response backpressure: RESP holds indefinitely; result_q is stable throughout.
- Reset asserted mid-transaction (EXEC or RESP):
  - Transaction is dropped; no response is produced.
  - All outputs take reset values immediately, without waiting for the clock edge.
- Simultaneous valid on both requesters in IDLE: exactly one ready; the loser is served next if still valid. With both continuously valid, grants alternate r0, r1, r0, ….
- rsp_ready asserted outside RESP, or by the non-granted requester: ignored.

## Test plan
- Single add: r0 op 000, a = 0x5555, b = 0x3333; bench ALU model returns 0x8888.
  - Expect r0_ready for one cycle, alu_a = 0x5555 next cycle.
  - r0_rsp_valid with result 0x8888, err 0, two cycles after acceptance.
- Contention: r0 (sub 0x9999, 0x3333) and r1 (xor 0x5555, 0xAAAA) valid in the same cycle after reset.
  - r0 served first (0x6666), then r1 (0xFFFF).
  - Repeat with both held valid: grants alternate.
- Backpressure: r1 response held with rsp_ready = 0 for 10 cycles.
  - rsp_valid and result stay constant; r0_valid raised meanwhile gets no ready until r1's handshake completes.
- Reserved opcode: r0 op 111 with alu_result = 0x1234 → rsp_result 0x0000, rsp_err 1.
- Reset mid-op: assert rst during EXEC → busy = 0 and all rsp_valid = 0 immediately.
  - After release, a new r1 request is accepted normally.
- Stray handshakes: rsp_ready pulses in IDLE and from the non-granted port → no state change, no response.
